// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    localparam int unsigned DEFAULT_PAT_W = 4;
    localparam int unsigned DEFAULT_CNT_W = 8;

    // The fill counter must be able to hold the value PAT_W itself.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic         sat_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (inc && (count_q != MAX)) begin
            count_q <= count_q + W'(1);
            if (count_q == MAX - W'(1)) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-loadable serial pattern detector with overlapping/non-overlapping
// matching and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W         = DEFAULT_PAT_W,
    parameter int unsigned      CNT_W         = DEFAULT_CNT_W,
    parameter logic [PAT_W-1:0] RESET_PAT     = {PAT_W{1'b1}},
    parameter logic             RESET_OVERLAP = MODE_OVERLAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int unsigned       FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              mode_q, mode_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q, y_d;

    logic [PAT_W-1:0]  win;
    logic [FILL_W-1:0] fill_n;
    logic              match;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= RESET_PAT;
            mode_q <= RESET_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    assign win    = {hist_q[PAT_W-2:0], din};
    assign fill_n = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);

    // fill_q is the EMPTY/FILLING/ARMED state; load wins over din_valid.
    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        match  = 1'b0;
        if (load) begin
            pat_d  = pattern;
            mode_d = overlap;
            fill_d = '0;
        end else if (din_valid) begin
            hist_d = win;
            if ((fill_n == FULL) && (win == pat_q)) begin
                match  = 1'b1;
                y_d    = 1'b1;
                // Non-overlapping: stale history stays in hist but is ignored until refilled.
                fill_d = (mode_q == MODE_OVERLAP) ? FULL : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (match),
        .clr  (count_clr),
        .count(match_count),
        .sat  (cnt_sat)
    );

    assign y = y_q;

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector: matches a runtime-loadable PAT_W-bit pattern on a 1-bit input stream, in overlapping or non-overlapping mode, and counts matches in a saturating counter. It is the general successor to the fixed three-ones detector and drops into the same serial-input slot, with a `din_valid` qualifier added so it can sit behind gapped or bursty sources.

## Interface
- `PAT_W`: default 4. Pattern length in bits, legal range 2..32.
- `CNT_W`: default 8. Width of the match counter.
- `RESET_PAT`: default `{PAT_W{1'b1}}`. Pattern held after reset.
- `RESET_OVERLAP`: default 1'b1. Mode after reset (1 = overlapping).

- `clk`  in  1  Single clock, rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `din`  in  1  Serial data bit.
- `din_valid`  in  1  `din` is sampled only when this is high.
- `load`  in  1  Latch `pattern` and `overlap`, then clear history.
- `pattern`  in  PAT_W  New pattern. The first-received bit is compared with `pattern[PAT_W-1]`.
- `overlap`  in  1  New mode, latched on `load`.
- `count_clr`  in  1  Clear `match_count` and `cnt_sat`.
- `y`  out  1  One-cycle match pulse, registered.
- `match_count`  out  CNT_W  Number of matches, saturating.
- `cnt_sat`  out  1  Sticky flag: the counter has reached its maximum value.

## Operation
- Internal state:
  - `pat_reg[PAT_W-1:0]`, `mode_reg`.
  - `hist[PAT_W-1:0]` shift register. The newest bit sits in the LSB.
  - `fill` counter, range 0..PAT_W.
- The fill counter acts as the state machine:
  - EMPTY: `fill` = 0.
  - FILLING: 0 < `fill` < PAT_W.
  - ARMED: `fill` = PAT_W.
- Accepted bit: `din_valid`=1 and `load`=0.
  - `win = {hist[PAT_W-2:0], din}`; `hist <= win`.
  - `fill_n = min(fill+1, PAT_W)`.
- Match: accepted bit, `fill_n == PAT_W` and `win == pat_reg`.
  - On a match, `y <= 1` and the counter increments.
  - Overlapping mode: `fill <= PAT_W` and the history is kept.
  - Non-overlapping mode: `fill <= 0`. `hist` is left as is but is not used until it has refilled.
- No match: `fill <= fill_n`.
- If `din_valid`=0: `hist` and `fill` hold, and `y <= 0`.
- `load`=1:
  - `pat_reg <= pattern`, `mode_reg <= overlap`, `fill <= 0`, `y <= 0`.
  - Any `din` in the same cycle is discarded.
  - `load` has priority over `din_valid`.
- `match_count`:
  - Increments by 1 per match.
  - Holds at `2^CNT_W-1`. `cnt_sat` is set on the cycle the counter reaches that value.
- `count_clr`:
  - Sets `match_count <= 0` and `cnt_sat <= 0`.
  - It has priority over a coincident increment. That match is not counted, but `y` still pulses.
- Reset values:
  - `y`=0, `match_count`=0, `cnt_sat`=0.
  - `fill`=0, `hist`=0.
  - `pat_reg`=RESET_PAT, `mode_reg`=RESET_OVERLAP.
- Reset has priority over all inputs. A reset mid-stream discards partial history; matching restarts from EMPTY.

## Timing
- `y` rises in the cycle after the rising edge that samples the final pattern bit, and lasts exactly one cycle.
- `match_count` updates on that same edge, so it is visible together with `y`.
- Overlapping mode with continuous valid input can assert `y` on consecutive cycles.
- After `load`, the first match can occur at the earliest on the PAT_W-th accepted bit after the `load` cycle.
- Changes on `pattern` and `overlap` have no effect unless `load` is high.
- Full throughput: one bit per cycle. There is no backpressure.

## Structure
- Package `seq_det_pkg`:
  - `MODE_OVERLAP` = 1'b1, `MODE_NONOVERLAP` = 1'b0.
  - Default `PAT_W` and `CNT_W` values.
  - `fill` width, computed as `$clog2(PAT_W+1)`.
- Sub-module `sat_counter` (parameter `W`; ports `inc`, `clr`, `count`, `sat`): implements `match_count` and `cnt_sat`.
- Top level contains the history register, fill logic, compare and `y` register.

## Test plan
- PAT_W=3, pattern 3'b111, overlapping; `din`=1 for 5 valid cycles -> `y` pulses after bits 3, 4 and 5; `match_count`=3.
- Same pattern, non-overlapping; `din`=1 for 6 cycles -> `y` pulses after bits 3 and 6 only; `match_count`=2.
- PAT_W=4, pattern 4'b1011, overlapping; stream 1,0,1,1,0,1,1 -> `y` pulses after bits 4 and 7; stream 1,0,1,0,1,1 -> one pulse, after bit 6.
- Pattern 4'b1011 with `din_valid` low for 2 cycles between each accepted bit -> still exactly one `y` pulse, one cycle after the 4th accepted bit; `y` stays 0 during gaps.
- `load` (3'b101) after two accepted 1s of pattern 3'b111, with `din`=1 valid in the load cycle -> that bit is discarded and no stale match occurs; the next 1,0,1 -> `y` after the third bit. Also: `reset` after 2 bits -> `fill`=0 and all outputs 0.
- CNT_W=2, 5 matches -> `match_count` holds at 3 and `cnt_sat`=1. Then `count_clr` coincident with a match -> `y`=1 and `match_count`=0, `cnt_sat`=0 on the next cycle.
